// File: rtl/shift_add_mult_pipe_if.sv
// Operand/result bundle for the pipelined shift-add multiplier.
// Handshake: a transfer happens on a rising clk edge when valid & ready are both 1.
// The sender holds its payload stable while valid=1 and ready=0. Ready never depends on valid.
interface shift_add_mult_pipe_if #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_a;
  logic [M-1:0]       in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [N+M-1:0]     out_result;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/shift_add_mult_pipe.sv
// M-stage shift-add multiplier, one multiplier bit per stage, signed or unsigned per operation.
// The pipeline stalls globally when the final stage holds a result that is not taken.
module shift_add_mult_pipe #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int TAG_W = 4
) (
  input logic                   clk,
  input logic                   rstn,
  shift_add_mult_pipe_if.slave  bus
);
  localparam int W = N + M;

  logic [M-1:0]              valid_q, valid_d;
  logic [M-1:0][W-1:0]       acc_q,   acc_d;
  logic [M-1:0][W-1:0]       mcand_q, mcand_d;
  logic [M-1:0][M-1:0]       mplier_q, mplier_d;
  logic [M-1:0]              sgn_q,   sgn_d;
  logic [M-1:0][TAG_W-1:0]   tag_q,   tag_d;
  logic                      stall;
  logic [W-1:0]              pp;

  always_comb begin
    stall    = valid_q[M-1] & ~bus.out_ready;
    valid_d  = '0;
    acc_d    = '0;
    mcand_d  = '0;
    mplier_d = '0;
    sgn_d    = '0;
    tag_d    = '0;
    pp       = '0;

    // Entry stage; the register only loads when not stalled, so this is the accept.
    if (bus.in_valid) begin
      valid_d[0]  = 1'b1;
      mcand_d[0]  = bus.in_signed ? {{M{bus.in_a[N-1]}}, bus.in_a} : {{M{1'b0}}, bus.in_a};
      mplier_d[0] = bus.in_b;
      sgn_d[0]    = bus.in_signed;
      tag_d[0]    = bus.in_tag;
      acc_d[0]    = bus.in_b[0] ? mcand_d[0] : '0;
    end

    for (int k = 1; k < M; k++) begin
      if (valid_q[k-1]) begin
        valid_d[k]  = 1'b1;
        mcand_d[k]  = mcand_q[k-1] << 1;
        mplier_d[k] = mplier_q[k-1] >> 1;
        sgn_d[k]    = sgn_q[k-1];
        tag_d[k]    = tag_q[k-1];
        pp          = mplier_d[k][0] ? mcand_d[k] : '0;
        // The multiplier MSB carries weight -2^(M-1) in two's complement.
        if (k == M-1 && sgn_q[k-1]) acc_d[k] = acc_q[k-1] - pp;
        else                        acc_d[k] = acc_q[k-1] + pp;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= '0;
      tag_q    <= '0;
    end else if (!stall) begin
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sgn_q    <= sgn_d;
      tag_q    <= tag_d;
    end
  end

  assign bus.in_ready   = ~stall;
  assign bus.out_valid  = valid_q[M-1];
  assign bus.out_result = acc_q[M-1];
  assign bus.out_tag    = tag_q[M-1];
  assign bus.busy       = |valid_q;
endmodule

// File: tb/tb_shift_add_mult_pipe.sv
// Bench for shift_add_mult_pipe: directed corners plus randomized traffic with backpressure,
// scored against an integer-arithmetic product model.
module tb_shift_add_mult_pipe;
  localparam int N = 8, M = 4, TAG_W = 4, W = N + M;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  shift_add_mult_pipe_if #(.N(N), .M(M), .TAG_W(TAG_W)) bus ();
  shift_add_mult_pipe #(.N(N), .M(M), .TAG_W(TAG_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [TAG_W+W-1:0] exp_q[$];
  logic [TAG_W+W:0]   prev_out;
  bit                 prev_stall = 1'b0;
  int                 cur_run = 0;
  int                 max_run = 0;
  bit                 rnd_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [M-1:0] b,
                                         input logic s);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[N-1]) sa = sa - (longint'(1) << N);
    if (s && b[M-1]) sb = sb - (longint'(1) << M);
    p = sa * sb;
    return p[W-1:0];
  endfunction

  // Monitor/scoreboard: samples mid-cycle, the values that the next rising edge will act on.
  always @(negedge clk) begin
    logic [TAG_W+W-1:0] e;
    if (!rstn) begin
      prev_stall = 1'b0;
      cur_run    = 0;
    end else begin
      check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_tag, model(bus.in_a, bus.in_b, bus.in_signed)});
      if (prev_stall)
        check("stall_hold", {bus.out_valid, bus.out_tag, bus.out_result}, prev_out);
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", {bus.out_tag, bus.out_result}, 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("result", bus.out_result, e[W-1:0]);
            check("tag", bus.out_tag, e[W +: TAG_W]);
          end
        end
      end else begin
        check("idle_zero", {bus.out_tag, bus.out_result}, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {1'b1, bus.out_tag, bus.out_result};
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [M-1:0] b, input logic s,
                      input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_tag    = tag;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.in_tag    = '0;
  endtask

  task automatic single(input logic [N-1:0] a, input logic [M-1:0] b, input logic s,
                        input logic [TAG_W-1:0] tag, input logic [W-1:0] expv);
    send(a, b, s, tag);
    idle();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check("latency_valid", bus.out_valid, (i == 3));
    end
    check("directed_result", bus.out_result, expv);
    check("directed_tag", bus.out_tag, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out", {bus.out_tag, bus.out_result}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned full-scale, then signed corners and the same operands unsigned.
    single(8'hFF, 4'hF, 1'b0, 4'd3, 12'hEF1);
    single(8'h80, 4'h8, 1'b1, 4'd4, 12'h400);
    single(8'h7F, 4'h8, 1'b1, 4'd5, 12'hC08);
    single(8'hFF, 4'hF, 1'b1, 4'd6, 12'h001);
    single(8'hFF, 4'hF, 1'b0, 4'd7, 12'hEF1);

    // Back-to-back: eight consecutive accepts produce eight consecutive outputs.
    max_run = 0;
    for (int t = 0; t < 8; t++)
      send(N'($urandom), M'($urandom), 1'($urandom), TAG_W'(t));
    idle();
    drain();
    check("b2b_run", max_run, 8);

    // Backpressure for three cycles while results are queued.
    fork
      begin
        for (int t = 0; t < 6; t++)
          send(N'($urandom), M'($urandom), 1'($urandom), TAG_W'(t + 8));
        idle();
      end
      begin
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
          @(posedge clk);
          #1;
        end
        check("bp_seen_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", bus.in_ready, 0);
          check("bp_out_valid", bus.out_valid, 1);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight.
    for (int t = 0; t < 3; t++)
      send(N'($urandom), M'($urandom), 1'($urandom), TAG_W'(t));
    idle();
    check("busy_inflight", bus.busy, 1);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out", {bus.out_tag, bus.out_result}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("postrst_busy", bus.busy, 0);

    // Bubbles with a zero multiplier: zero products separated by gap cycles.
    max_run = 0;
    for (int t = 0; t < 6; t++) begin
      send(N'($urandom), 4'h0, 1'($urandom), TAG_W'(t));
      idle();
      @(posedge clk);
      #1;
    end
    drain();
    check("bubble_run", max_run, 1);

    // Random traffic with random input gaps and random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          if ($urandom_range(0, 2) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
          send(N'($urandom), M'($urandom), 1'($urandom), TAG_W'($urandom));
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
